// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core constants: register file geometry and write-back source ids
package cpu_pkg;

    localparam int DEF_REGISTER_WIDTH      = 32;
    localparam int DEF_REGISTER_ADDR_WIDTH = 5;

    typedef enum logic {
        SRC_PIPE = 1'b0,
        SRC_LONG = 1'b1
    } src_id_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - write-back request channels and register file write port
interface rf_wb_arbiter_if
    import cpu_pkg::*;
#(
    parameter int REGISTER_WIDTH      = DEF_REGISTER_WIDTH,
    parameter int REGISTER_ADDR_WIDTH = DEF_REGISTER_ADDR_WIDTH
);

    logic                           src0_valid;
    logic                           src0_ready;
    logic [REGISTER_ADDR_WIDTH-1:0] src0_addr;
    logic [REGISTER_WIDTH-1:0]      src0_data;

    logic                           src1_valid;
    logic                           src1_ready;
    logic [REGISTER_ADDR_WIDTH-1:0] src1_addr;
    logic [REGISTER_WIDTH-1:0]      src1_data;

    logic                           rf_we;
    logic [REGISTER_ADDR_WIDTH-1:0] rf_wd_addr;
    logic [REGISTER_WIDTH-1:0]      rf_wd_data;

    modport master (
        output src0_valid, src0_addr, src0_data,
        output src1_valid, src1_addr, src1_data,
        input  src0_ready, src1_ready,
        input  rf_we, rf_wd_addr, rf_wd_data
    );

    modport slave (
        input  src0_valid, src0_addr, src0_data,
        input  src1_valid, src1_addr, src1_data,
        output src0_ready, src1_ready,
        output rf_we, rf_wd_addr, rf_wd_data
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-request round-robin arbiter remembering the last winner
module rr_arb2
    import cpu_pkg::*;
(
    input  logic    cpu_clk,
    input  logic    cpu_rst,
    input  logic    req0,
    input  logic    req1,
    output logic    gnt0,
    output logic    gnt1,
    output src_id_e gnt_id
);

    src_id_e last_grant;

    // Grant the lone requester; under contention favour the source that lost last time
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!cpu_rst) begin
            if (req0 && (!req1 || last_grant == SRC_LONG)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        gnt_id = gnt1 ? SRC_LONG : SRC_PIPE;
    end

    // Remember the winner of every transfer; src1 starts as "last" so src0 wins first
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            last_grant <= SRC_LONG;
        end else if (gnt0) begin
            last_grant <= SRC_PIPE;
        end else if (gnt1) begin
            last_grant <= SRC_LONG;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register file write-back arbiter with long-latency busy scoreboard
module rf_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int REGISTER_WIDTH      = DEF_REGISTER_WIDTH,
    parameter int REGISTER_ADDR_WIDTH = DEF_REGISTER_ADDR_WIDTH
)(
    input  logic                           cpu_clk,
    input  logic                           cpu_rst,
    rf_wb_arbiter_if.slave                 wb,
    input  logic                           sb_set,
    input  logic [REGISTER_ADDR_WIDTH-1:0] sb_set_addr,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_addr,
    output logic                           rs1_busy,
    output logic                           rs2_busy
);

    localparam int NUM_REGS = 2 ** REGISTER_ADDR_WIDTH;

    logic                           gnt0;
    logic                           gnt1;
    src_id_e                        gnt_id;
    logic                           xfer;
    logic [REGISTER_ADDR_WIDTH-1:0] sel_addr;
    logic [REGISTER_WIDTH-1:0]      sel_data;
    src_id_e                        rf_src;
    logic [NUM_REGS-1:0]            busy;
    logic [NUM_REGS-1:0]            busy_nxt;

    rr_arb2 u_arb (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .req0    (wb.src0_valid),
        .req1    (wb.src1_valid),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gnt_id  (gnt_id)
    );

    assign wb.src0_ready = gnt0;
    assign wb.src1_ready = gnt1;
    assign xfer          = gnt0 | gnt1;

    // Steer the granted source onto the write path
    always_comb begin
        sel_addr = gnt1 ? wb.src1_addr : wb.src0_addr;
        sel_data = gnt1 ? wb.src1_data : wb.src0_data;
    end

    // Register the selected write; x0 is accepted but never enabled
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            wb.rf_we      <= 1'b0;
            wb.rf_wd_addr <= '0;
            wb.rf_wd_data <= '0;
            rf_src        <= SRC_PIPE;
        end else begin
            wb.rf_we <= xfer && (sel_addr != '0);
            if (xfer) begin
                wb.rf_wd_addr <= sel_addr;
                wb.rf_wd_data <= sel_data;
                rf_src        <= gnt_id;
            end
        end
    end

    // Clear on a long-latency commit, then set on issue so a back-to-back op keeps the bit
    always_comb begin
        busy_nxt = busy;
        if (wb.rf_we && rf_src == SRC_LONG) begin
            busy_nxt[wb.rf_wd_addr] = 1'b0;
        end
        if (sb_set) begin
            busy_nxt[sb_set_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard state
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];

endmodule
